// File: rtl/imem_boot_loader_pkg.sv
// mips_boot_pkg: shared state encoding and framing constants for the instruction-memory boot loader.
package mips_boot_pkg;
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} boot_state_t;
    localparam int BOOT_CNT_W = 16;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output rx_valid, rx_data, input rx_ready, imem_we, imem_addr, imem_wdata);
    modport slave (input rx_valid, rx_data, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader_packer.sv
// boot_word_packer: assembles little-endian bytes into words and pulses word_valid the cycle after the last byte.
module boot_word_packer
    import mips_boot_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              last_byte,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);
    logic [1:0]        bcnt;
    logic [DATA_W-9:0] sr;
    assign last_byte = in_valid && bcnt == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt       <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= last_byte;
            if (clear) bcnt <= '0;
            else if (in_valid) begin
                bcnt <= bcnt + 2'd1;
                sr   <= {in_data, sr[DATA_W-9:8]};
            end
            if (last_byte) word <= {in_data, sr};
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed byte stream into instruction memory, holding the core in reset until done.
// Optional BOOT_CHECKSUM_EN adds a trailing 8-bit checksum byte and the CSUM state.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_restart,
    imem_boot_loader_if.slave     bus,
    output logic                  core_rst_n,
    output logic                  boot_done,
    output logic                  boot_err
);
    boot_state_t           state, nxt;
    logic                  acc, clr, in_valid, last_byte, word_valid, too_big;
    logic [DATA_W-1:0]     word;
    logic [7:0]            cnt_lo;
    logic [BOOT_CNT_W-1:0] n, rem;
    logic [ADDR_W-1:0]     addr;
    assign bus.rx_ready  = state inside {HDR0, HDR1, DATA, CSUM};
    assign acc           = bus.rx_valid && bus.rx_ready;
    assign clr           = (state == DONE || state == ERR) && boot_restart;
    assign in_valid      = acc && state == DATA;
    assign n             = {bus.rx_data, cnt_lo};
    assign too_big       = 32'(n) > (32'd1 << ADDR_W);
    assign bus.imem_we   = word_valid;
    assign bus.imem_addr = addr;
    assign bus.imem_wdata = word;

    boot_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clr),
        .in_valid  (in_valid),
        .in_data   (bus.rx_data),
        .last_byte (last_byte),
        .word_valid(word_valid),
        .word      (word)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else sum <= state == HDR0 ? 8'd0 : in_valid ? sum + bus.rx_data : sum;
    end
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            HDR0: if (acc) nxt = HDR1;
            HDR1: if (acc) nxt = n == '0 ? DONE : too_big ? ERR : DATA;
            DATA: if (last_byte && rem == BOOT_CNT_W'(1)) begin
`ifdef BOOT_CHECKSUM_EN
                nxt = CSUM;
`else
                nxt = DONE;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: if (acc) nxt = 8'(sum + bus.rx_data) == 8'd0 ? DONE : ERR;
`endif
            DONE, ERR: if (boot_restart) nxt = HDR0;
            default: nxt = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR0;
            core_rst_n <= 1'b0;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
            cnt_lo     <= '0;
            rem        <= '0;
            addr       <= '0;
        end else begin
            state      <= nxt;
            core_rst_n <= nxt == DONE;
            boot_done  <= nxt == DONE;
            boot_err   <= nxt == ERR;
            if (state == HDR0 && acc) cnt_lo <= bus.rx_data;
            if (state == HDR1 && acc) rem <= n;
            else if (last_byte) rem <= rem - BOOT_CNT_W'(1);
            addr <= clr ? '0 : addr + ADDR_W'(word_valid);
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized frames checked against a frame-level reference model.
module tb_imem_boot_loader;
    typedef logic [7:0] bq_t[$];
    logic clk = 1'b0, rst_n = 1'b0, boot_restart = 1'b0;
    logic core_rst_n, boot_done, boot_err;
    int n_chk = 0, n_fail = 0;
    logic [39:0] wlog[$];

    imem_boot_loader_if #(.ADDR_W(8)) bus ();
    imem_boot_loader #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boot_restart(boot_restart),
        .bus         (bus),
        .core_rst_n  (core_rst_n),
        .boot_done   (boot_done),
        .boot_err    (boot_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bq_t with_csum(input bq_t f, input bit bad);
        bq_t r = f;
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] s = 8'd0;
        for (int i = 2; i < f.size(); i++) s += f[i];
        r.push_back(8'(-s) + 8'(bad));
`endif
        return r;
    endfunction

    function automatic bq_t mk_frame(input int n, input bit bad);
        bq_t f;
        f.push_back(8'(n));
        f.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
        return (n == 0 || n > 256) ? f : with_csum(f, bad);
    endfunction

    task automatic send(input bq_t f, input bit gaps);
        foreach (f[i]) begin
            if (gaps && $urandom_range(3) == 0) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            bus.rx_valid = 1'b1;
            bus.rx_data  = f[i];
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
        end
    endtask

    // Reference: expected outcome and write list come straight from the frame bytes.
    task automatic run(input bq_t f, input bit gaps, input string tag);
        int n;
        bit ok;
        logic [39:0] exp[$];
        logic [7:0] s;
        wlog.delete();
        send(f, gaps);
        n = int'(f[0]) | (int'(f[1]) << 8);
        ok = n <= 256;
        if (n >= 1 && n <= 256) begin
            for (int i = 0; i < n; i++)
                exp.push_back({8'(i), f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]});
`ifdef BOOT_CHECKSUM_EN
            s = 8'd0;
            for (int i = 2; i < f.size(); i++) s += f[i];
            ok = s == 8'd0;
`else
            s = 8'd0;
            chk({tag, "_we_at_done"}, 40'(bus.imem_we), 40'd1);
`endif
        end
        chk({tag, "_done"}, 40'(boot_done), 40'(ok));
        chk({tag, "_err"}, 40'(boot_err), 40'(!ok));
        chk({tag, "_core_rst_n"}, 40'(core_rst_n), 40'(ok));
        chk({tag, "_rx_ready"}, 40'(bus.rx_ready), 40'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_nwrites"}, 40'(wlog.size()), 40'(exp.size()));
        foreach (exp[i]) chk({tag, "_write"}, i < wlog.size() ? wlog[i] : 'x, exp[i]);
    endtask

    task automatic restart(input string tag);
        boot_restart = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h05;
        @(posedge clk);
        #1;
        boot_restart = 1'b0;
        bus.rx_valid = 1'b0;
        chk({tag, "_rx_ready"}, 40'(bus.rx_ready), 40'd1);
        chk({tag, "_core_rst_n"}, 40'(core_rst_n), 40'd0);
        chk({tag, "_flags"}, 40'({boot_done, boot_err}), 40'd0);
        chk({tag, "_addr"}, 40'(bus.imem_addr), 40'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"}, 40'(bus.rx_ready), 40'd1);
        chk({tag, "_we"}, 40'(bus.imem_we), 40'd0);
        chk({tag, "_addr"}, 40'(bus.imem_addr), 40'd0);
        chk({tag, "_wdata"}, 40'(bus.imem_wdata), 40'd0);
        chk({tag, "_outs"}, 40'({core_rst_n, boot_done, boot_err}), 40'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(with_csum('{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b0), 1'b0, "t1");
        chk("t1_w0", wlog.size() > 0 ? wlog[0] : 'x, {8'd0, 32'h12345678});
        chk("t1_w1", wlog.size() > 1 ? wlog[1] : 'x, {8'd1, 32'hDEADBEEF});
        restart("t5_restart");

        run('{8'h00, 8'h00}, 1'b0, "t2_empty");
        restart("t2_restart");

        run('{8'h01, 8'h01}, 1'b0, "t3_too_big");
        restart("t3_restart");

        send('{8'h01, 8'h00, 8'hAA, 8'hBB}, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset("t4_async");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(mk_frame(1, 1'b0), 1'b0, "t4_reload");
        restart("t4_restart");

        for (int k = 0; k < 6; k++) begin
            run(mk_frame(int'($urandom_range(1, 6)), 1'b0), 1'b1, "rand");
            restart("rand_restart");
        end

        run(mk_frame(256, 1'b0), 1'b0, "full");
        chk("full_addr_wrap", 40'(bus.imem_addr), 40'd0);
        restart("full_restart");

`ifdef BOOT_CHECKSUM_EN
        run('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6}, 1'b0, "t6_good");
        restart("t6_restart");
        run('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7}, 1'b0, "t6_bad");
        restart("t6_restart2");
        run(mk_frame(3, 1'b1), 1'b1, "csum_rand_bad");
        restart("csum_restart");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
